// File: rtl/prog_loader_if.sv
// Stream, CPU-side and memory-side signals of the program loader, bundled for port use.
// The loader takes the slave view; whoever drives the stream and CPU side takes the master view.
interface prog_loader_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  byte_valid_i;
    logic [7:0]            byte_data_i;
    logic                  byte_ready_o;
    logic [ADDR_WIDTH-1:0] cpu_addr_i;
    logic [15:0]           cpu_value_i;
    logic                  cpu_enable_i;
    logic                  cpu_wr_en_i;
    logic                  cpu_rd_en_i;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [15:0]           mem_value_o;
    logic                  mem_enable_o;
    logic                  mem_wr_en_o;
    logic                  mem_rd_en_o;
    logic                  cpu_rst_o;
    logic                  load_done_o;
    logic                  load_err_o;
    logic [15:0]           words_loaded_o;

    modport slave (
        input  byte_valid_i, byte_data_i,
        input  cpu_addr_i, cpu_value_i, cpu_enable_i, cpu_wr_en_i, cpu_rd_en_i,
        output byte_ready_o,
        output mem_addr_o, mem_value_o, mem_enable_o, mem_wr_en_o, mem_rd_en_o,
        output cpu_rst_o, load_done_o, load_err_o, words_loaded_o
    );

    modport master (
        output byte_valid_i, byte_data_i,
        output cpu_addr_i, cpu_value_i, cpu_enable_i, cpu_wr_en_i, cpu_rd_en_i,
        input  byte_ready_o,
        input  mem_addr_o, mem_value_o, mem_enable_o, mem_wr_en_o, mem_rd_en_o,
        input  cpu_rst_o, load_done_o, load_err_o, words_loaded_o
    );
endinterface

// File: rtl/prog_loader.sv
// Loads a big-endian, word-count-prefixed byte stream into memory from address 0,
// then hands the memory port to the CPU and releases CPU reset.
module prog_loader #(
    parameter int ADDR_WIDTH = 12
) (
    input logic          clk_i,
    input logic          rst_i,
    prog_loader_if.slave bus
);
    localparam logic [2:0] HDR_HI = 3'd0;
    localparam logic [2:0] HDR_LO = 3'd1;
    localparam logic [2:0] DAT_HI = 3'd2;
    localparam logic [2:0] DAT_LO = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] RUN    = 3'd5;

    // One bit wider than the counter so a depth of 2**16 still compares correctly.
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

    logic [2:0]  state;
    logic [15:0] n;
    logic [15:0] word;
    logic [15:0] cnt;
    logic        err;
    logic        fire;
    logic        in_range;
    logic [15:0] n_next;
    logic [15:0] cnt_next;

    assign bus.byte_ready_o = !rst_i && (state inside {HDR_HI, HDR_LO, DAT_HI, DAT_LO});
    assign fire             = bus.byte_valid_i && bus.byte_ready_o;
    assign n_next           = {n[15:8], bus.byte_data_i};
    assign cnt_next         = cnt + 16'd1;
    assign in_range         = {1'b0, cnt} < DEPTH;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= HDR_HI;
            n     <= '0;
            word  <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                HDR_HI: if (fire) begin
                    n[15:8] <= bus.byte_data_i;
                    state   <= HDR_LO;
                end
                HDR_LO: if (fire) begin
                    n     <= n_next;
                    state <= (n_next == 16'd0) ? RUN : DAT_HI;
                    if ({1'b0, n_next} > DEPTH) err <= 1'b1;
                end
                DAT_HI: if (fire) begin
                    word[15:8] <= bus.byte_data_i;
                    state      <= DAT_LO;
                end
                DAT_LO: if (fire) begin
                    word[7:0] <= bus.byte_data_i;
                    state     <= WRITE;
                end
                WRITE: begin
                    cnt   <= cnt_next;
                    state <= (cnt_next == n) ? RUN : DAT_HI;
                end
                RUN: ;
                default: state <= HDR_HI;
            endcase
        end
    end

    // Out-of-range words are still consumed and counted, only the strobe is dropped.
    always_comb begin
        bus.mem_addr_o   = '0;
        bus.mem_value_o  = '0;
        bus.mem_enable_o = 1'b0;
        bus.mem_wr_en_o  = 1'b0;
        bus.mem_rd_en_o  = 1'b0;
        case (state)
            WRITE: begin
                bus.mem_addr_o   = cnt[ADDR_WIDTH-1:0];
                bus.mem_value_o  = word;
                bus.mem_enable_o = in_range;
                bus.mem_wr_en_o  = in_range;
            end
            RUN: begin
                bus.mem_addr_o   = bus.cpu_addr_i;
                bus.mem_value_o  = bus.cpu_value_i;
                bus.mem_enable_o = bus.cpu_enable_i;
                bus.mem_wr_en_o  = bus.cpu_wr_en_i;
                bus.mem_rd_en_o  = bus.cpu_rd_en_i;
            end
            default: ;
        endcase
    end

    assign bus.cpu_rst_o      = (state != RUN);
    assign bus.load_done_o    = (state == RUN);
    assign bus.load_err_o     = err;
    assign bus.words_loaded_o = cnt;
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboarded bench for prog_loader: a 12-bit and a 4-bit instance, random source gaps,
// expected writes derived from the byte image and checked by independent write monitors.
module tb_prog_loader;
    typedef logic [7:0] bq_t[$];
    typedef struct packed { logic [15:0] addr; logic [15:0] val; } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_WIDTH(12)) if12 ();
    prog_loader_if #(.ADDR_WIDTH(4))  if4 ();

    prog_loader #(.ADDR_WIDTH(12)) dut12 (.clk_i(clk), .rst_i(rst), .bus(if12));
    prog_loader #(.ADDR_WIDTH(4))  dut4  (.clk_i(clk), .rst_i(rst), .bus(if4));

    wr_t         q12[$];
    wr_t         q4[$];
    logic [15:0] mem12[4096];
    logic [15:0] exp12[4096];
    logic [15:0] mem4[16];
    logic [15:0] exp4[16];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wr4_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Behavioural memories fed by the DUT memory port
    always @(posedge clk) begin
        if (if12.mem_enable_o && if12.mem_wr_en_o) mem12[if12.mem_addr_o] <= if12.mem_value_o;
        if (if4.mem_enable_o && if4.mem_wr_en_o) mem4[if4.mem_addr_o] <= if4.mem_value_o;
    end

    // Write monitors: every load-phase write must match the next expected write
    always @(negedge clk) begin : mon12
        wr_t e;
        if (!rst && if12.cpu_rst_o) begin
            if (if12.mem_wr_en_o) begin
                chk("wr12_ready_low", 32'(if12.byte_ready_o), 32'd0);
                if (q12.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wr12_unexpected addr=%h value=%h required=none", if12.mem_addr_o, if12.mem_value_o);
                end else begin
                    e = q12.pop_front();
                    chk("wr12_addr", 32'(if12.mem_addr_o), 32'(e.addr));
                    chk("wr12_value", 32'(if12.mem_value_o), 32'(e.val));
                    chk("wr12_enable", 32'(if12.mem_enable_o), 32'd1);
                end
            end else begin
                chk("idle12_mem_quiet", {if12.mem_enable_o, if12.mem_rd_en_o}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin : mon4
        wr_t e;
        if (!rst && if4.cpu_rst_o) begin
            if (if4.mem_wr_en_o) begin
                wr4_cnt++;
                chk("wr4_ready_low", 32'(if4.byte_ready_o), 32'd0);
                if (q4.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wr4_unexpected addr=%h value=%h required=none", if4.mem_addr_o, if4.mem_value_o);
                end else begin
                    e = q4.pop_front();
                    chk("wr4_addr", 32'(if4.mem_addr_o), 32'(e.addr));
                    chk("wr4_value", 32'(if4.mem_value_o), 32'(e.val));
                    chk("wr4_enable", 32'(if4.mem_enable_o), 32'd1);
                end
            end else begin
                chk("idle4_mem_quiet", {if4.mem_enable_o, if4.mem_rd_en_o}, 32'd0);
            end
        end
    end

    // Reference: word i of the image lands at address i when it fits in the memory
    task automatic model(input bq_t bs, input bit use4, output int n);
        int depth;
        logic [15:0] w;
        depth = use4 ? 16 : 4096;
        n = int'({bs[0], bs[1]});
        for (int i = 0; i < n && (3 + 2 * i) < bs.size(); i++) begin
            w = {bs[2 + 2 * i], bs[3 + 2 * i]};
            if (i < depth) begin
                if (use4) begin q4.push_back('{addr: 16'(i), val: w}); exp4[i] = w; end
                else begin q12.push_back('{addr: 16'(i), val: w}); exp12[i] = w; end
            end
        end
    endtask

    task automatic drive(input bit use4, input logic v, input logic [7:0] d);
        if (use4) begin if4.byte_valid_i = v; if4.byte_data_i = d; end
        else begin if12.byte_valid_i = v; if12.byte_data_i = d; end
    endtask

    task automatic send(input bq_t bs, input bit use4, input int gap_pct, output int first_cyc);
        first_cyc = -1;
        foreach (bs[k]) begin
            bit sent;
            bit fire;
            bit v;
            int budget;
            int c;
            sent = 0;
            budget = 100;
            while (!sent && budget > 0) begin
                @(negedge clk);
                v = ($urandom_range(99) >= gap_pct);
                drive(use4, v, bs[k]);
                #1;
                fire = v && (use4 ? if4.byte_ready_o : if12.byte_ready_o);
                c = cyc;
                @(posedge clk);
                if (fire) begin
                    sent = 1;
                    if (first_cyc < 0) first_cyc = c;
                end
                budget--;
            end
            if (!sent) begin
                checks++; failures++;
                $display("FAIL byte_accept_timeout index=%0d actual=not_accepted required=accepted", k);
            end
        end
        #1 drive(use4, 1'b0, 8'h00);
    endtask

    task automatic wait_done(input bit use4, output int at);
        at = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (use4 ? if4.load_done_o : if12.load_done_o) begin at = cyc; break; end
        end
        if (at < 0) begin
            checks++; failures++;
            $display("FAIL run_timeout actual=load_done_low required=load_done_high");
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t img;
        bq_t hdr;
        bq_t body;
        int n, t0, t1;
        logic [15:0] w;

        for (int i = 0; i < 4096; i++) begin mem12[i] = '0; exp12[i] = '0; end
        for (int i = 0; i < 16; i++) begin mem4[i] = '0; exp4[i] = '0; end
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        if12.cpu_addr_i = '0; if12.cpu_value_i = '0;
        if12.cpu_enable_i = 0; if12.cpu_wr_en_i = 0; if12.cpu_rd_en_i = 0;
        if4.cpu_addr_i = '0; if4.cpu_value_i = '0;
        if4.cpu_enable_i = 0; if4.cpu_wr_en_i = 0; if4.cpu_rd_en_i = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst12_cpu_rst", 32'(if12.cpu_rst_o), 32'd1);
        chk("rst12_flags", {if12.byte_ready_o, if12.load_done_o, if12.load_err_o}, 32'd0);
        chk("rst12_mem", {if12.mem_addr_o, if12.mem_value_o, if12.mem_enable_o, if12.mem_wr_en_o, if12.mem_rd_en_o}, 32'd0);
        chk("rst12_words", 32'(if12.words_loaded_o), 32'd0);
        chk("rst4_cpu_rst", 32'(if4.cpu_rst_o), 32'd1);
        chk("rst4_flags", {if4.byte_ready_o, if4.load_done_o, if4.load_err_o}, 32'd0);
        chk("rst4_mem", {if4.mem_addr_o, if4.mem_value_o, if4.mem_enable_o, if4.mem_wr_en_o, if4.mem_rd_en_o}, 32'd0);
        rst = 1'b0;

        // Basic load, no gaps: a waiting byte is held through each WRITE cycle
        img = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
        model(img, 0, n);
        send(img, 0, 0, t0);
        wait_done(0, t1);
        chk("basic_latency", 32'(t1 - t0), 32'd11);
        chk("basic_cpu_rst", 32'(if12.cpu_rst_o), 32'd0);
        chk("basic_words", 32'(if12.words_loaded_o), 32'(n));
        chk("basic_err", 32'(if12.load_err_o), 32'd0);
        chk("basic_q_empty", 32'(q12.size()), 32'd0);
        for (int i = 0; i < 3; i++) chk("basic_mem", 32'(mem12[i]), 32'(exp12[i]));

        // RUN pass-through with a toggling byte source
        @(negedge clk);
        if12.cpu_addr_i = 12'h005; if12.cpu_value_i = 16'hBEEF;
        if12.cpu_enable_i = 1; if12.cpu_wr_en_i = 1; if12.cpu_rd_en_i = 0;
        drive(0, 1'b1, 8'h77);
        #1;
        chk("pass_addr", 32'(if12.mem_addr_o), 32'h005);
        chk("pass_value", 32'(if12.mem_value_o), 32'hBEEF);
        chk("pass_ctrl", {if12.mem_enable_o, if12.mem_wr_en_o, if12.mem_rd_en_o}, 32'b110);
        chk("pass_ready", 32'(if12.byte_ready_o), 32'd0);
        exp12[5] = 16'hBEEF;
        @(negedge clk);
        if12.cpu_addr_i = 12'h007; if12.cpu_wr_en_i = 0; if12.cpu_rd_en_i = 1;
        drive(0, 1'b0, 8'h00);
        #1;
        chk("pass_rd_addr", 32'(if12.mem_addr_o), 32'h007);
        chk("pass_rd_ctrl", {if12.mem_enable_o, if12.mem_wr_en_o, if12.mem_rd_en_o}, 32'b101);
        @(negedge clk);
        if12.cpu_enable_i = 0; if12.cpu_rd_en_i = 0; if12.cpu_addr_i = '0; if12.cpu_value_i = '0;
        drive(0, 1'b1, 8'h99);
        #1;
        chk("pass_words_held", 32'(if12.words_loaded_o), 32'd3);
        chk("pass_mem5", 32'(mem12[5]), 32'(exp12[5]));
        drive(0, 1'b0, 8'h00);

        // Reset after the first word of a 3-word load, then reload one word
        pulse_rst();
        img = '{8'h00, 8'h03, 8'h12, 8'h34};
        model(img, 0, n);
        send(img, 0, 0, t0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_first_write", 32'(q12.size()), 32'd0);
        chk("midrst_words", 32'(if12.words_loaded_o), 32'd0);
        chk("midrst_cpu_rst", 32'(if12.cpu_rst_o), 32'd1);
        img = '{8'h00, 8'h01, 8'h55, 8'hAA};
        model(img, 0, n);
        send(img, 0, 0, t0);
        wait_done(0, t1);
        chk("midrst_words_after", 32'(if12.words_loaded_o), 32'd1);
        chk("midrst_mem0", 32'(mem12[0]), 32'(exp12[0]));
        chk("midrst_mem1", 32'(mem12[1]), 32'(exp12[1]));
        chk("midrst_q_empty", 32'(q12.size()), 32'd0);

        // Empty image: RUN right after the header, later bytes refused
        pulse_rst();
        img = '{8'h00, 8'h00};
        model(img, 0, n);
        send(img, 0, 0, t0);
        wait_done(0, t1);
        chk("empty_latency", 32'(t1 - t0), 32'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, 1'b1, 8'h12);
            #1;
            chk("empty_ready", 32'(if12.byte_ready_o), 32'd0);
            chk("empty_no_wr", 32'(if12.mem_wr_en_o), 32'd0);
        end
        drive(0, 1'b0, 8'h00);
        chk("empty_words", 32'(if12.words_loaded_o), 32'd0);
        chk("empty_done", {if12.load_done_o, if12.cpu_rst_o}, 32'b10);

        // Source gaps: basic image then random images
        for (int r = 0; r < 4; r++) begin
            pulse_rst();
            if (r == 0) img = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
            else begin
                img.delete();
                n = $urandom_range(6, 1);
                img.push_back(8'(n >> 8));
                img.push_back(8'(n));
                for (int k = 0; k < n; k++) begin
                    w = 16'($urandom);
                    img.push_back(w[15:8]);
                    img.push_back(w[7:0]);
                end
            end
            model(img, 0, n);
            send(img, 0, 40, t0);
            wait_done(0, t1);
            chk("gap_words", 32'(if12.words_loaded_o), 32'(n));
            chk("gap_err", 32'(if12.load_err_o), 32'd0);
            chk("gap_q_empty", 32'(q12.size()), 32'd0);
            for (int i = 0; i < n; i++) chk("gap_mem", 32'(mem12[i]), 32'(exp12[i]));
        end

        // Overflow on the 16-word instance: 18 words, last two dropped
        pulse_rst();
        wr4_cnt = 0;
        img = '{8'h00, 8'h12};
        for (int i = 0; i < 18; i++) begin img.push_back(8'h00); img.push_back(8'(i)); end
        model(img, 1, n);
        hdr = img[0:1];
        body = img[2:$];
        send(hdr, 1, 0, t0);
        chk("ovf_err_after_hdr", 32'(if4.load_err_o), 32'd1);
        send(body, 1, 20, t0);
        wait_done(1, t1);
        chk("ovf_words", 32'(if4.words_loaded_o), 32'd18);
        chk("ovf_err_hold", 32'(if4.load_err_o), 32'd1);
        chk("ovf_pulses", 32'(wr4_cnt), 32'd16);
        chk("ovf_q_empty", 32'(q4.size()), 32'd0);
        for (int i = 0; i < 16; i++) chk("ovf_mem", 32'(mem4[i]), 32'(exp4[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
